// File: rtl/gb_cart_pkg.sv
// Shared types for the Game Boy cartridge responder:
// FSM state encoding and address-region decode.
package gb_cart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_MEM_WAIT,
        S_DRIVE,
        S_COMMIT,
        S_WAIT_END
    } state_t;

    typedef enum logic [1:0] {
        RG_ROM0,
        RG_ROMX,
        RG_RAM,
        RG_NONE
    } region_t;

    localparam logic [1:0] ROM0_A15_14 = 2'b00;
    localparam logic [1:0] ROMX_A15_14 = 2'b01;
    localparam logic       MBC_A15     = 1'b0;
    localparam logic [2:0] RAM_A15_13  = 3'b101;

    // MBC register select, addr[14:13] within the ROM window
    localparam logic [1:0] MBC_RAMEN = 2'd0;
    localparam logic [1:0] MBC_ROMB  = 2'd1;
    localparam logic [1:0] MBC_RAMB  = 2'd2;

    function automatic region_t addr_region(input logic [15:0] a);
        if (a[15:14] == ROM0_A15_14) return RG_ROM0;
        if (a[15:14] == ROMX_A15_14) return RG_ROMX;
        if (a[15:13] == RAM_A15_13) return RG_RAM;
        return RG_NONE;
    endfunction

endpackage

// File: rtl/gb_pin_sync.sv
// Multi-flop synchronizer for a group of asynchronous cartridge pins.
module gb_pin_sync #(
    parameter int             W       = 1,
    parameter int             STAGES  = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o
);

    logic [W-1:0] ff_q [STAGES];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) ff_q[i] <= RST_VAL;
        end else begin
            ff_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) ff_q[i] <= ff_q[i-1];
        end
    end

    assign sync_o = ff_q[STAGES-1];

endmodule

// File: rtl/gb_cart_responder.sv
// Cartridge-bus target: MBC registers, ROM/RAM memory bridge
// and camera register window behind synchronized pins.
module gb_cart_responder
    import gb_cart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MEM_ADDR_W  = 23
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  pin_clk,
    input  logic                  pin_wr_n,
    input  logic                  pin_rd_n,
    input  logic                  pin_cs_n,
    input  logic [15:0]           pin_addr,
    input  logic [7:0]            pin_data_in,
    output logic [7:0]            pin_data_out,
    output logic                  pin_data_oe,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_sel,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic                  cam_wr,
    output logic [6:0]            cam_idx,
    output logic [7:0]            cam_wdata,
    input  logic                  cam_busy,
    output logic [5:0]            rom_bank,
    output logic [3:0]            ram_bank,
    output logic                  cam_en,
    output logic                  ram_wr_en
);

    localparam logic [3:0] SETTLE = 4'(SYNC_STAGES + 1);

    logic [3:0]  strb_s;
    logic        clk_s, cs_n_s, rd_n_s, wr_n_s;
    logic [15:0] addr_s;
    logic [7:0]  data_s;

    gb_pin_sync #(.W(4), .STAGES(SYNC_STAGES), .RST_VAL(4'b0111)) u_sync_strb (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .async_i ({pin_clk, pin_cs_n, pin_rd_n, pin_wr_n}),
        .sync_o  (strb_s)
    );

    gb_pin_sync #(.W(16), .STAGES(SYNC_STAGES), .RST_VAL(16'h0)) u_sync_addr (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .async_i (pin_addr),
        .sync_o  (addr_s)
    );

    gb_pin_sync #(.W(8), .STAGES(SYNC_STAGES), .RST_VAL(8'h0)) u_sync_data (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .async_i (pin_data_in),
        .sync_o  (data_s)
    );

    assign {clk_s, cs_n_s, rd_n_s, wr_n_s} = strb_s;

    logic [15:0] addr_prev_q, addr_cap_q;
    logic        addr_ok_q;
    logic [7:0]  data_prev_q, data_cap_q;
    logic        clk_prev_q;
    logic [3:0]  settle_q;
    logic        armed_q;

    // After reset no cycle starts until both strobes are seen idle,
    // so a bus cycle interrupted by reset is never picked up again.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            addr_prev_q <= '0;
            addr_cap_q  <= '0;
            addr_ok_q   <= 1'b0;
            data_prev_q <= '0;
            data_cap_q  <= '0;
            clk_prev_q  <= 1'b0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            addr_prev_q <= addr_s;
            addr_ok_q   <= (addr_s == addr_prev_q);
            if (addr_s == addr_prev_q) addr_cap_q <= addr_s;
            data_prev_q <= data_s;
            if (data_s == data_prev_q) data_cap_q <= data_s;
            clk_prev_q <= clk_s;
            if (settle_q != SETTLE) settle_q <= settle_q + 4'd1;
            if (settle_q == SETTLE && rd_n_s && wr_n_s) armed_q <= 1'b1;
        end
    end

    state_t                state_q;
    logic                  is_wr_q, abort_q;
    logic [15:0]           addr_q;
    logic [7:0]            wdata_q;
    logic [5:0]            rom_bank_q;
    logic [3:0]            ram_bank_q;
    logic                  cam_en_q, ram_wr_en_q;
    logic                  mem_req_q, mem_we_q, mem_sel_q;
    logic [MEM_ADDR_W-1:0] mem_addr_q;
    logic [7:0]            mem_wdata_q;
    logic                  cam_wr_q;
    logic [6:0]            cam_idx_q;
    logic [7:0]            cam_wdata_q;
    logic                  oe_q;
    logic [7:0]            dout_q;

    region_t               rgn;
    logic                  claim, wr_latch;
    logic [MEM_ADDR_W-1:0] ram_addr, rd_addr;

    assign rgn      = addr_region(addr_q);
    assign claim    = (rgn == RG_ROM0) || (rgn == RG_ROMX) ||
                      (rgn == RG_RAM && !cs_n_s);
    assign wr_latch = wr_n_s || (clk_s && !clk_prev_q);
    assign ram_addr = MEM_ADDR_W'({ram_bank_q, addr_q[12:0]});

    always_comb begin
        rd_addr = ram_addr;
        case (rgn)
            RG_ROM0: rd_addr = MEM_ADDR_W'(addr_q[13:0]);
            RG_ROMX: rd_addr = MEM_ADDR_W'({rom_bank_q, addr_q[13:0]});
            default: rd_addr = ram_addr;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            is_wr_q     <= 1'b0;
            abort_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rom_bank_q  <= 6'd1;
            ram_bank_q  <= '0;
            cam_en_q    <= 1'b0;
            ram_wr_en_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cam_wr_q    <= 1'b0;
            cam_idx_q   <= '0;
            cam_wdata_q <= '0;
            oe_q        <= 1'b0;
            dout_q      <= '0;
        end else begin
            cam_wr_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (armed_q && addr_ok_q && (!rd_n_s || !wr_n_s)) begin
                        is_wr_q <= !wr_n_s;
                        addr_q  <= addr_cap_q;
                        abort_q <= 1'b0;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!claim) begin
                        state_q <= S_WAIT_END;
                    end else if (is_wr_q) begin
                        if (wr_latch) begin
                            wdata_q <= data_cap_q;
                            state_q <= S_COMMIT;
                        end
                    end else if (rgn == RG_RAM && cam_en_q) begin
                        dout_q  <= (addr_q[6:0] == 7'd0) ? {7'b0, cam_busy} : 8'h00;
                        oe_q    <= 1'b1;
                        state_q <= S_DRIVE;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_sel_q  <= (rgn == RG_RAM);
                        mem_addr_q <= rd_addr;
                        state_q    <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (rd_n_s) abort_q <= 1'b1;
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (abort_q || rd_n_s) begin
                            state_q <= S_IDLE;
                        end else begin
                            dout_q  <= mem_rdata;
                            oe_q    <= 1'b1;
                            state_q <= S_DRIVE;
                        end
                    end
                end
                S_DRIVE: begin
                    if (rd_n_s) begin
                        oe_q    <= 1'b0;
                        state_q <= S_WAIT_END;
                    end
                end
                S_COMMIT: begin
                    if (addr_q[15] == MBC_A15) begin
                        unique case (addr_q[14:13])
                            MBC_RAMEN: ram_wr_en_q <= (wdata_q[3:0] == 4'hA);
                            MBC_ROMB:  rom_bank_q  <= wdata_q[5:0];
                            MBC_RAMB: begin
                                cam_en_q   <= wdata_q[4];
                                ram_bank_q <= wdata_q[3:0];
                            end
                            default: ;
                        endcase
                        state_q <= S_WAIT_END;
                    end else if (cam_en_q) begin
                        cam_wr_q    <= 1'b1;
                        cam_idx_q   <= addr_q[6:0];
                        cam_wdata_q <= wdata_q;
                        state_q     <= S_WAIT_END;
                    end else if (!ram_wr_en_q) begin
                        state_q <= S_WAIT_END;
                    end else if (!mem_req_q) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_sel_q   <= 1'b1;
                        mem_addr_q  <= ram_addr;
                        mem_wdata_q <= wdata_q;
                    end else if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= S_WAIT_END;
                    end
                end
                S_WAIT_END: begin
                    if (rd_n_s && wr_n_s) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pin_data_out = dout_q;
    assign pin_data_oe  = oe_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_sel      = mem_sel_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cam_wr       = cam_wr_q;
    assign cam_idx      = cam_idx_q;
    assign cam_wdata    = cam_wdata_q;
    assign rom_bank     = rom_bank_q;
    assign ram_bank     = ram_bank_q;
    assign cam_en       = cam_en_q;
    assign ram_wr_en    = ram_wr_en_q;

endmodule

// File: tb/tb_gb_cart_responder.sv
// Scoreboard bench for gb_cart_responder: random bus cycles against
// a behavioural cartridge model, plus directed abort and reset cases.
module tb_gb_cart_responder;

    localparam int EV_MEM = 0;
    localparam int EV_CAM = 1;
    localparam int EV_DRV = 2;

    typedef struct {
        int         kind;
        logic       sel;
        logic       we;
        int         addr;
        logic [7:0] data;
    } ev_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        pin_clk = 1'b0;
    logic        pin_wr_n = 1'b1;
    logic        pin_rd_n = 1'b1;
    logic        pin_cs_n = 1'b1;
    logic [15:0] pin_addr = 16'h0;
    logic [7:0]  pin_data_in = 8'h0;
    logic [7:0]  pin_data_out;
    logic        pin_data_oe;
    logic        mem_req, mem_we, mem_sel;
    logic [22:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h0;
    logic        cam_wr;
    logic [6:0]  cam_idx;
    logic [7:0]  cam_wdata;
    logic        cam_busy = 1'b0;
    logic [5:0]  rom_bank;
    logic [3:0]  ram_bank;
    logic        cam_en, ram_wr_en;

    gb_cart_responder #(.SYNC_STAGES(2), .MEM_ADDR_W(23)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .pin_clk      (pin_clk),
        .pin_wr_n     (pin_wr_n),
        .pin_rd_n     (pin_rd_n),
        .pin_cs_n     (pin_cs_n),
        .pin_addr     (pin_addr),
        .pin_data_in  (pin_data_in),
        .pin_data_out (pin_data_out),
        .pin_data_oe  (pin_data_oe),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .cam_wr       (cam_wr),
        .cam_idx      (cam_idx),
        .cam_wdata    (cam_wdata),
        .cam_busy     (cam_busy),
        .rom_bank     (rom_bank),
        .ram_bank     (ram_bank),
        .cam_en       (cam_en),
        .ram_wr_en    (ram_wr_en)
    );

    always #5 clk_sys = ~clk_sys;

    int         checks = 0;
    int         errors = 0;
    ev_t        exp_q[$];
    int         ack_dly = 2;
    logic [7:0] rd_nxt = 8'h00;

    int   m_rom = 1;
    int   m_ramb = 0;
    logic m_cam = 1'b0;
    logic m_ramwe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic s, input logic w, input int a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.sel = s;
        e.we = w;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic model_write(input logic [15:0] a, input logic [7:0] d, input logic cs);
        int ai;
        ai = int'(a);
        if (ai < 'h2000) m_ramwe = (d % 16 == 10);
        else if (ai < 'h4000) m_rom = d % 64;
        else if (ai < 'h6000) begin
            m_cam = ((d / 16) % 2) == 1;
            m_ramb = d % 16;
        end else if (ai >= 'hA000 && ai < 'hC000 && !cs) begin
            if (m_cam) push(EV_CAM, 1'b0, 1'b0, ai % 128, d);
            else if (m_ramwe) push(EV_MEM, 1'b1, 1'b1, m_ramb * 'h2000 + ai % 'h2000, d);
        end
    endtask

    task automatic model_read(input logic [15:0] a, input logic cs, input logic [7:0] rd,
                              input logic busy, input logic abort, output logic drv);
        int   ai, ma;
        logic sel, mem;
        ai = int'(a);
        ma = 0;
        sel = 1'b0;
        mem = 1'b0;
        drv = 1'b0;
        if (ai < 'h4000) begin
            mem = 1'b1;
            ma = ai % 'h4000;
        end else if (ai < 'h8000) begin
            mem = 1'b1;
            ma = m_rom * 'h4000 + ai % 'h4000;
        end else if (ai >= 'hA000 && ai < 'hC000 && !cs) begin
            if (m_cam) begin
                drv = 1'b1;
                push(EV_DRV, 1'b0, 1'b0, 0, (ai % 128 == 0) ? {7'b0, busy} : 8'h00);
            end else begin
                mem = 1'b1;
                sel = 1'b1;
                ma = m_ramb * 'h2000 + ai % 'h2000;
            end
        end
        if (mem) begin
            push(EV_MEM, sel, 1'b0, ma, 8'h00);
            if (!abort) begin
                drv = 1'b1;
                push(EV_DRV, 1'b0, 1'b0, 0, rd);
            end
        end
    endtask

    task automatic chk_regs();
        chk("rom_bank", 32'(rom_bank), m_rom);
        chk("ram_bank", 32'(ram_bank), m_ramb);
        chk("cam_en", 32'(cam_en), 32'(m_cam));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(m_ramwe));
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input logic cs);
        model_write(a, d, cs);
        pin_addr = a;
        pin_data_in = d;
        pin_cs_n = cs;
        idle(6);
        pin_wr_n = 1'b0;
        idle(5);
        if ($urandom_range(1, 0) == 1) begin
            pin_clk = 1'b1;
            idle(3);
            pin_clk = 1'b0;
        end
        idle(2);
        pin_wr_n = 1'b1;
        idle(3);
        pin_cs_n = 1'b1;
        idle(25);
        chk_regs();
    endtask

    task automatic bus_read(input logic [15:0] a, input logic cs, input logic [7:0] rd,
                            input int dly, input logic busy);
        logic drv;
        rd_nxt = rd;
        ack_dly = dly;
        cam_busy = busy;
        model_read(a, cs, rd, busy, 1'b0, drv);
        pin_addr = a;
        pin_cs_n = cs;
        idle(6);
        pin_rd_n = 1'b0;
        idle(30);
        if (drv) chk("oe_held", 32'(pin_data_oe), 1);
        pin_rd_n = 1'b1;
        idle(4);
        chk("oe_release", 32'(pin_data_oe), 0);
        pin_cs_n = 1'b1;
        idle(20);
    endtask

    task automatic observe(input int kind, input logic s, input logic w, input int a, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event kind=%0d addr=%0h data=%0h required=none", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", kind, e.kind);
            if (kind == e.kind) begin
                if (kind == EV_MEM) begin
                    chk("mem_sel", 32'(s), 32'(e.sel));
                    chk("mem_we", 32'(w), 32'(e.we));
                    chk("mem_addr", a, e.addr);
                    if (e.we) chk("mem_wdata", 32'(d), 32'(e.data));
                end else if (kind == EV_CAM) begin
                    chk("cam_idx", a, e.addr);
                    chk("cam_wdata", 32'(d), 32'(e.data));
                end else begin
                    chk("drv_data", 32'(d), 32'(e.data));
                end
            end
        end
    endtask

    initial begin : monitor
        logic req_p, oe_p;
        req_p = 1'b0;
        oe_p = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (mem_req && !req_p) observe(EV_MEM, mem_sel, mem_we, int'(mem_addr), mem_wdata);
            if (cam_wr) observe(EV_CAM, 1'b0, 1'b0, int'(cam_idx), cam_wdata);
            if (pin_data_oe && !oe_p) observe(EV_DRV, 1'b0, 1'b0, 0, pin_data_out);
            req_p = mem_req;
            oe_p = pin_data_oe;
        end
    end

    initial begin : responder
        logic [22:0] a0;
        forever begin
            @(negedge clk_sys);
            if (mem_req) begin
                a0 = mem_addr;
                repeat (ack_dly) @(negedge clk_sys);
                chk("req_hold", 32'(mem_req), 1);
                chk("addr_hold", 32'(mem_addr), 32'(a0));
                mem_rdata = rd_nxt;
                mem_ack = 1'b1;
                @(negedge clk_sys);
                mem_ack = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic        drv;
        int          op;
        logic [15:0] a;
        logic [7:0]  d;
        logic        cs;

        idle(5);
        reset_n = 1'b1;
        idle(10);
        chk("rst_rom_bank", 32'(rom_bank), 1);
        chk("rst_ram_bank", 32'(ram_bank), 0);
        chk("rst_cam_en", 32'(cam_en), 0);
        chk("rst_ram_wr_en", 32'(ram_wr_en), 0);
        chk("rst_oe", 32'(pin_data_oe), 0);
        chk("rst_req", 32'(mem_req), 0);

        bus_write(16'h2100, 8'h05, 1'b1);
        bus_read(16'h4123, 1'b1, 8'hA5, 3, 1'b0);

        bus_write(16'h0000, 8'h0A, 1'b1);
        bus_write(16'h4000, 8'h03, 1'b1);
        bus_write(16'hA010, 8'h5A, 1'b0);
        bus_write(16'h0000, 8'h00, 1'b1);
        bus_write(16'hA010, 8'h5A, 1'b0);

        bus_write(16'h4000, 8'h10, 1'b1);
        bus_write(16'hA000, 8'h01, 1'b0);
        bus_read(16'hA000, 1'b0, 8'h77, 0, 1'b1);
        bus_read(16'hA005, 1'b0, 8'h77, 0, 1'b1);
        bus_write(16'h4000, 8'h00, 1'b1);

        rd_nxt = 8'h3C;
        ack_dly = 12;
        model_read(16'h0100, 1'b1, 8'h3C, 1'b0, 1'b1, drv);
        pin_addr = 16'h0100;
        idle(6);
        pin_rd_n = 1'b0;
        idle(4);
        pin_rd_n = 1'b1;
        idle(6);
        chk("abort_req_hold", 32'(mem_req), 1);
        idle(20);
        chk("abort_req_done", 32'(mem_req), 0);
        chk("abort_no_oe", 32'(pin_data_oe), 0);
        bus_read(16'h0100, 1'b1, 8'hC3, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(5, 0);
            d = 8'($urandom);
            cs = ($urandom_range(3, 0) == 0);
            ack_dly = $urandom_range(8, 0);
            case (op)
                0: begin
                    a = 16'($urandom_range(16'h7FFF, 0));
                    if ($urandom_range(1, 0) == 1) d[3:0] = 4'hA;
                    bus_write(a, d, 1'b1);
                end
                1: bus_write(16'hA000 + 16'($urandom_range(16'h1FFF, 0)), d, cs);
                2: bus_read(16'($urandom_range(16'h7FFF, 0)), cs, d, ack_dly, 1'($urandom));
                3: bus_read(16'hA000 + 16'($urandom_range(16'h1FFF, 0)), cs, d, ack_dly, 1'($urandom));
                4: bus_read(16'h8000 + 16'($urandom_range(16'h1FFF, 0)), 1'b0, d, ack_dly, 1'b0);
                default: bus_write(16'hC000 + 16'($urandom_range(16'h3FFF, 0)), d, 1'b0);
            endcase
        end

        bus_write(16'h2000, 8'h07, 1'b1);
        rd_nxt = 8'h66;
        ack_dly = 0;
        model_read(16'h4000, 1'b1, 8'h66, 1'b0, 1'b0, drv);
        pin_addr = 16'h4000;
        idle(6);
        pin_rd_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (pin_data_oe) break;
            idle(1);
        end
        chk("drive_reached", 32'(pin_data_oe), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_drive_oe", 32'(pin_data_oe), 0);
        chk("rst_drive_req", 32'(mem_req), 0);
        m_rom = 1;
        m_ramb = 0;
        m_cam = 1'b0;
        m_ramwe = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(20);
        chk("rst_rel_oe", 32'(pin_data_oe), 0);
        chk_regs();
        pin_rd_n = 1'b1;
        idle(10);

        pin_addr = 16'h2000;
        pin_data_in = 8'h09;
        idle(6);
        pin_wr_n = 1'b0;
        idle(6);
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(15);
        pin_wr_n = 1'b1;
        idle(15);
        chk("rst_no_commit", 32'(rom_bank), 1);

        bus_read(16'h4001, 1'b1, 8'h99, 2, 1'b0);

        idle(10);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
